// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file slave.
// FSM state encoding plus ACK and open-drain levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK_CHK,
        WAIT_STOP
    } slave_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic OE_RELEASE = 1'b1;
    localparam logic OE_DRIVE   = 1'b0;

endpackage

// File: rtl/i2c_in_filter.sv
// Synchronizer, majority-free run-length glitch filter and edge detect
// for one asynchronous bus line; level resets to the idle-high state.
module i2c_in_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]          sync;
    logic [FILT_LEN-1:0] hist;
    logic                prev;

    // A new level is accepted only after FILT_LEN equal synchronized samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            hist  <= '1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            hist <= (hist << 1) | FILT_LEN'(sync[1]);
            if (&hist) begin
                level <= 1'b1;
            end else if (~|hist) begin
                level <= 1'b0;
            end
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a small byte register file, auto-incrementing pointer
// and a host-side combinational peek port.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         MEM_DEPTH  = 16,
    parameter int         FILT_LEN   = 3,
    localparam int        PTR_W      = $clog2(MEM_DEPTH)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             scl_oe,
    input  logic [PTR_W-1:0] peek_addr,
    output logic [7:0]       peek_data,
    output logic             busy,
    output logic             start_det,
    output logic             stop_det,
    output logic             wr_strobe
);

    logic scl_f;
    logic scl_rise;
    logic scl_fall;
    logic sda_f;
    logic sda_rise;
    logic sda_fall;

    i2c_in_filter #(
        .FILT_LEN(FILT_LEN)
    ) u_scl_filt (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .raw  (scl_in),
        .level(scl_f),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_in_filter #(
        .FILT_LEN(FILT_LEN)
    ) u_sda_filt (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .raw  (sda_in),
        .level(sda_f),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    slave_state_t     state;
    slave_state_t     state_n;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_n;
    logic             sda_oe_n;
    logic             busy_n;
    logic             we;
    logic [7:0]       rx_byte;
    logic             start;
    logic             stop;
    logic [7:0]       mem [MEM_DEPTH];

    assign start   = sda_fall & scl_f;
    assign stop    = sda_rise & scl_f;
    assign rx_byte = {shreg[6:0], sda_f};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            sda_oe  <= OE_RELEASE;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            ptr     <= ptr_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ptr_n     = ptr;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        we        = 1'b0;
        if (stop) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = OE_RELEASE;
            busy_n    = 1'b0;
        end else if (start) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = OE_RELEASE;
        end else begin
            unique case (state)
                IDLE: begin
                    sda_oe_n = OE_RELEASE;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                // First fall drives the ACK, second fall releases and moves on.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (sda_oe == OE_RELEASE) begin
                            sda_oe_n = OE_DRIVE;
                        end else begin
                            sda_oe_n  = OE_RELEASE;
                            bit_cnt_n = '0;
                            if (state == ADDR_ACK && shreg[0]) begin
                                state_n  = RDATA;
                                sda_oe_n = mem[ptr][7];
                                shreg_n  = {mem[ptr][6:0], 1'b0};
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                state_n = WDATA;
                            end
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ptr_n   = rx_byte[PTR_W-1:0];
                            state_n = PTR_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            we      = 1'b1;
                            ptr_n   = ptr + PTR_W'(1);
                            state_n = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        sda_oe_n = shreg[7];
                        shreg_n  = {shreg[6:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = RACK_CHK;
                        end
                    end
                end
                RACK_CHK: begin
                    if (scl_fall) begin
                        sda_oe_n = OE_RELEASE;
                    end
                    if (scl_rise) begin
                        bit_cnt_n = '0;
                        if (sda_f == ACK) begin
                            ptr_n   = ptr + PTR_W'(1);
                            shreg_n = mem[ptr + PTR_W'(1)];
                            state_n = RDATA;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: begin
                    sda_oe_n = OE_RELEASE;
                end
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = OE_RELEASE;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[ptr] <= rx_byte;
        end
    end

    assign peek_data = mem[peek_addr];
    assign scl_oe    = OE_RELEASE;
    assign start_det = start;
    assign stop_det  = stop;
    assign wr_strobe = we;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed and random I2C master transactions against a byte-array
// reference model of the slave register file.
module tb_i2c_slave_regfile;

    localparam int HB = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic       scl_oe;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    logic       wr_strobe;
    logic [3:0] peek_addr = 4'd0;
    logic [7:0] peek_data;
    logic       sda_bus;

    assign sda_bus = m_sda & sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .SLAVE_ADDR(7'h50),
        .MEM_DEPTH (16),
        .FILT_LEN  (3)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .scl_oe   (scl_oe),
        .peek_addr(peek_addr),
        .peek_data(peek_data),
        .busy     (busy),
        .start_det(start_det),
        .stop_det (stop_det),
        .wr_strobe(wr_strobe)
    );

    int n_chk = 0;
    int n_fail = 0;

    int wr_cnt = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int low_cnt = 0;
    int busy_cnt = 0;
    int viol_cnt = 0;
    logic oe_prev = 1'b1;
    logic cap_done = 1'b0;
    logic cap_pend = 1'b0;
    logic [7:0] cap_old = 8'h00;
    logic [7:0] cap_new = 8'h00;

    // Background bus observer: pulse counters, drive-while-scl-high check,
    // and a capture of peek_data around the very first register write.
    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
        if (sda_oe === 1'b0) low_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (!rst && sda_oe !== oe_prev && m_scl) viol_cnt++;
        oe_prev = sda_oe;
        if (cap_pend) begin
            cap_new = peek_data;
            cap_pend = 1'b0;
        end
        if (wr_strobe && !cap_done) begin
            cap_old = peek_data;
            cap_pend = 1'b1;
            cap_done = 1'b1;
        end
    end

    logic [7:0] ref_mem [16];
    logic [3:0] ref_ptr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (m_scl == 1'b0) begin
            cyc(HB / 2);
            m_sda = 1'b1;
            cyc(HB / 2);
            m_scl = 1'b1;
        end
        cyc(HB);
        m_sda = 1'b0;
        cyc(HB);
        m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        cyc(HB / 2);
        m_sda = 1'b0;
        cyc(HB / 2);
        m_scl = 1'b1;
        cyc(HB);
        m_sda = 1'b1;
        cyc(HB);
    endtask

    task automatic bit_xfer(input logic b, input logic g, output logic r);
        cyc(HB / 2);
        m_sda = b;
        cyc(HB / 2);
        m_scl = 1'b1;
        cyc(4);
        if (g) begin
            m_scl = 1'b0;
            cyc(2);
            m_scl = 1'b1;
        end else begin
            cyc(2);
        end
        cyc(4);
        r = sda_bus;
        cyc(HB / 2);
        m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] gm,
                              output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], gm[i], r);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, r);
            d[i] = r;
        end
        bit_xfer(nack, 1'b0, r);
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        peek_addr = a;
        cyc(1);
        d = peek_data;
    endtask

    task automatic model_write(input logic [7:0] d);
        ref_mem[ref_ptr] = d;
        ref_ptr = ref_ptr + 4'd1;
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        logic [7:0] p;
        logic [6:0] xa;
        int         w0;
        int         s0;
        int         p0;
        int         l0;
        int         b0;
        int         n;
        int         op;

        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_ptr = 4'd0;

        cyc(4);
        chk("rst_sda_oe", sda_oe, 1);
        chk("rst_scl_oe", scl_oe, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {start_det, stop_det, wr_strobe}, 0);
        rst = 1'b0;
        cyc(4);
        peek(4'd0, d);
        chk("rst_mem0", d, 8'h00);

        // Write two bytes from pointer 3, watching the peek of register 3.
        peek_addr = 4'd3;
        w0 = wr_cnt;
        p0 = stop_cnt;
        bus_start();
        write_byte(8'hA0, 8'h00, a);
        chk("wr_addr_ack", a, 0);
        write_byte(8'h03, 8'h00, a);
        chk("wr_ptr_ack", a, 0);
        ref_ptr = 4'd3;
        write_byte(8'h5A, 8'h00, a);
        chk("wr_d0_ack", a, 0);
        model_write(8'h5A);
        write_byte(8'hC3, 8'h00, a);
        chk("wr_d1_ack", a, 0);
        model_write(8'hC3);
        chk("wr_busy_mid", busy, 1);
        bus_stop();
        chk("wr_busy_after", busy, 0);
        chk("wr_strobes", wr_cnt - w0, 2);
        chk("wr_stop_pulse", stop_cnt - p0, 1);
        chk("peek_old_same_cycle", cap_old, 8'h00);
        chk("peek_new_next_cycle", cap_new, 8'h5A);
        peek(4'd3, d);
        chk("wr_mem3", d, ref_mem[3]);
        peek(4'd4, d);
        chk("wr_mem4", d, ref_mem[4]);

        // Pointer write, repeated START, two-byte read.
        s0 = start_cnt;
        bus_start();
        write_byte(8'hA0, 8'h00, a);
        chk("rd_addr_ack", a, 0);
        write_byte(8'h03, 8'h00, a);
        chk("rd_ptr_ack", a, 0);
        ref_ptr = 4'd3;
        bus_start();
        write_byte(8'hA1, 8'h00, a);
        chk("rd_raddr_ack", a, 0);
        read_byte(1'b0, d);
        chk("rd_byte0", d, ref_mem[ref_ptr]);
        ref_ptr = ref_ptr + 4'd1;
        read_byte(1'b1, d);
        chk("rd_byte1", d, ref_mem[ref_ptr]);
        cyc(10);
        chk("rd_release_after_nack", sda_oe, 1);
        bus_stop();
        chk("rd_start_pulses", start_cnt - s0, 2);
        chk("rd_busy_after", busy, 0);

        // Foreign address: never driven, never busy, nothing written.
        l0 = low_cnt;
        b0 = busy_cnt;
        w0 = wr_cnt;
        bus_start();
        write_byte(8'hA2, 8'h00, a);
        chk("mm_addr_nack", a, 1);
        write_byte(8'h11, 8'h00, a);
        chk("mm_data_nack", a, 1);
        bus_stop();
        chk("mm_no_drive", low_cnt - l0, 0);
        chk("mm_no_busy", busy_cnt - b0, 0);
        chk("mm_no_write", wr_cnt - w0, 0);

        // Pointer wrap: 15 -> 0 -> 1, confirmed by a current-address read.
        bus_start();
        write_byte(8'hA0, 8'h00, a);
        write_byte(8'h01, 8'h00, a);
        ref_ptr = 4'd1;
        write_byte(8'hE7, 8'h00, a);
        model_write(8'hE7);
        bus_stop();
        bus_start();
        write_byte(8'hA0, 8'h00, a);
        write_byte(8'h0F, 8'h00, a);
        ref_ptr = 4'd15;
        write_byte(8'h01, 8'h00, a);
        model_write(8'h01);
        write_byte(8'h02, 8'h00, a);
        chk("wrap_ack", a, 0);
        model_write(8'h02);
        bus_stop();
        peek(4'd15, d);
        chk("wrap_mem15", d, 8'h01);
        peek(4'd0, d);
        chk("wrap_mem0", d, 8'h02);
        bus_start();
        write_byte(8'hA1, 8'h00, a);
        read_byte(1'b1, d);
        chk("wrap_ptr_is_1", d, ref_mem[ref_ptr]);
        bus_stop();

        // scl glitch inside the address byte must be filtered out.
        bus_start();
        write_byte(8'hA0, 8'h12, a);
        chk("glitch_addr_ack", a, 0);
        write_byte(8'h08, 8'h00, a);
        ref_ptr = 4'd8;
        write_byte(8'h77, 8'h00, a);
        chk("glitch_data_ack", a, 0);
        model_write(8'h77);
        bus_stop();
        peek(4'd8, d);
        chk("glitch_mem8", d, ref_mem[8]);

        // STOP after half a data byte discards it.
        w0 = wr_cnt;
        bus_start();
        write_byte(8'hA0, 8'h00, a);
        write_byte(8'h07, 8'h00, a);
        ref_ptr = 4'd7;
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, a);
        bus_stop();
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_busy", busy, 0);
        peek(4'd7, d);
        chk("abort_mem7", d, ref_mem[7]);
        bus_start();
        write_byte(8'hA1, 8'h00, a);
        chk("abort_idle_ack", a, 0);
        read_byte(1'b1, d);
        chk("abort_ptr_kept", d, ref_mem[ref_ptr]);
        bus_stop();

        // Reset while the slave is driving a zero data bit.
        bus_start();
        write_byte(8'hA0, 8'h00, a);
        write_byte(8'h05, 8'h00, a);
        ref_ptr = 4'd5;
        write_byte(8'h12, 8'h00, a);
        model_write(8'h12);
        bus_stop();
        bus_start();
        write_byte(8'hA0, 8'h00, a);
        write_byte(8'h05, 8'h00, a);
        bus_start();
        write_byte(8'hA1, 8'h00, a);
        cyc(10);
        chk("rstmid_driving", sda_oe, 0);
        rst = 1'b1;
        cyc(1);
        chk("rstmid_release", sda_oe, 1);
        cyc(2);
        rst = 1'b0;
        m_sda = 1'b1;
        m_scl = 1'b1;
        cyc(HB);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_ptr = 4'd0;
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            chk("rstmid_mem_clear", d, 8'h00);
        end

        // Random writes, pointer-set reads and foreign-address traffic.
        for (int t = 0; t < 10; t++) begin
            op = int'($urandom_range(0, 2));
            p = 8'($urandom);
            n = int'($urandom_range(1, 3));
            bus_start();
            if (op == 0) begin
                write_byte(8'hA0, 8'h00, a);
                chk("rnd_w_addr_ack", a, 0);
                write_byte(p, 8'h00, a);
                chk("rnd_w_ptr_ack", a, 0);
                ref_ptr = p[3:0];
                for (int j = 0; j < n; j++) begin
                    d = 8'($urandom);
                    write_byte(d, 8'h00, a);
                    chk("rnd_w_data_ack", a, 0);
                    model_write(d);
                end
            end else if (op == 1) begin
                write_byte(8'hA0, 8'h00, a);
                write_byte(p, 8'h00, a);
                ref_ptr = p[3:0];
                bus_start();
                write_byte(8'hA1, 8'h00, a);
                chk("rnd_r_addr_ack", a, 0);
                for (int j = 0; j < n; j++) begin
                    read_byte(j == n - 1, d);
                    chk("rnd_r_data", d, ref_mem[ref_ptr]);
                    if (j != n - 1) ref_ptr = ref_ptr + 4'd1;
                end
            end else begin
                xa = 7'($urandom_range(0, 127));
                if (xa == 7'h50) xa = 7'h51;
                write_byte({xa, 1'b0}, 8'h00, a);
                chk("rnd_mm_nack", a, 1);
                write_byte(p, 8'h00, a);
                chk("rnd_mm_data_nack", a, 1);
            end
            bus_stop();
            p = 8'($urandom);
            peek(p[3:0], d);
            chk("rnd_peek", d, ref_mem[p[3:0]]);
        end

        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            chk("final_mem", d, ref_mem[i]);
        end
        chk("sda_change_while_scl_high", viol_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
